write_channel_controller: RTL
=============================

# write_channel_controller

Write-path sequencer directly downstream of the write arbiter in the 2-master/1-slave AXI interconnect. It takes the arbiter's Channel_Request and Selected_Slave and returns Channel_Granted to it. It routes the selected master's AW, W and B channels to the single downstream slave port for exactly one burst. It holds the channel until the write response completes, then reopens arbitration.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT_CYCLES, 256, response watchdog limit (used only with WR_TIMEOUT_EN)
- ACLK  input  1  clock
- ARESETN  input  1  asynchronous active-low reset
- Channel_Request  input  1  from arbiter: a master has awvalid while channel free
- Selected_Slave  input  1  from arbiter: index of granted master, 0 = S00, 1 = S01
- Channel_Granted  output  1  to arbiter: high only in IDLE
- S0x_AXI_awaddr/awlen/awsize/awburst/awvalid  input  ADDR_W/8/3/2/1  master x AW, x ∈ {0,1}
- S0x_AXI_awready  output  1  master x AW ready
- S0x_AXI_wdata/wstrb/wlast/wvalid  input  DATA_W/DATA_W/8/1/1  master x W; wlast ignored
- S0x_AXI_wready  output  1  master x W ready
- S0x_AXI_bresp/bvalid  output  2/1  master x B
- S0x_AXI_bready  input  1  master x B ready
- M00_AXI_awaddr/awlen/awsize/awburst/awvalid  output  ADDR_W/8/3/2/1  slave AW
- M00_AXI_awready  input  1  slave AW ready
- M00_AXI_wdata/wstrb/wlast/wvalid  output  DATA_W/DATA_W/8/1/1  slave W
- M00_AXI_wready  input  1  slave W ready
- M00_AXI_bresp/bvalid  input  2/1  slave B
- M00_AXI_bready  output  1  slave B ready

## Operation
- FSM states: IDLE, ADDR, DATA, RESP, plus ERR with WR_TIMEOUT_EN.
- IDLE:
  - Channel_Granted=1; all slave-side valids/readies and master-side readies/bvalid are 0.
  - Channel_Request=1 moves to ADDR on the next edge. The arbiter latches Selected_Slave on that same edge.
- ADDR:
  - M00 AW fields and awvalid come combinationally from master[Selected_Slave].
  - That master's awready = M00_AXI_awready. The other master's awready = 0.
  - On the AW handshake: latch awlen into len_q, clear the 8-bit beat counter, go to DATA.
- DATA:
  - W is routed from master[Selected_Slave]. M00_AXI_wlast = (beat_cnt == len_q), generated locally.
  - beat_cnt increments on each wvalid&wready.
  - The handshake with wlast=1 moves to RESP.
- RESP:
  - M00 bresp/bvalid are routed to the selected master; M00_AXI_bready = that master's bready.
  - The B handshake moves to IDLE.
- The non-selected master sees awready=wready=bvalid=0 and bresp=0 in every state.
- Selected_Slave is stable outside IDLE because Channel_Granted=0 freezes it.

## Timing
- Reset: state=IDLE, len_q=0, beat_cnt=0, timeout counter=0, Channel_Granted=1, every other output 0.
- Reset mid-burst aborts to IDLE immediately. There is no response to the interrupted master.
- Overhead is one cycle IDLE→ADDR after the request. AW, W and B are zero-latency combinational pass-through. Each handshake advances state on the same edge.
- Single beat (awlen=0): wlast=1 on the first beat.
- awlen=255: beat_cnt reaches 255 without wrap, wlast asserted on beat 256.
- A master dropping awvalid in ADDR is an AXI violation; the FSM remains in ADDR.
- Back-to-back bursts: the B handshake edge returns to IDLE, so the earliest next AW is 2 cycles after the B handshake.

## Configuration
- WR_TIMEOUT_EN defined:
  - A 16-bit counter runs in RESP while M00_AXI_bvalid=0.
  - When it reaches TIMEOUT_CYCLES, go to ERR.
  - ERR drives the selected master bvalid=1, bresp=2'b10 (SLVERR), and M00_AXI_bready=0.
  - The master's bready returns the FSM to IDLE. A late slave B is never forwarded.
  - The counter clears on entering RESP.
- WR_TIMEOUT_EN undefined: no counter and no ERR state; RESP waits indefinitely.

## Test plan
- Reset → Channel_Granted=1, M00_AXI_awvalid=0, all master readies 0.
- S00 awvalid, awaddr=0x1000, awlen=3; slave always ready → 4 W beats routed, M00 wlast only on beat 4, bresp=0 to S00, back in IDLE with Channel_Granted=1.
- S00 and S01 awvalid together → S00 served first; S01 is served after S00's B handshake, and S01 sees awready=0 throughout S00's burst.
- S01 burst awlen=0 with slave wready held low 5 cycles → single beat, wlast=1, transfer completes on the cycle wready rises.
- ARESETN pulsed low during DATA beat 2 → all outputs return to reset values; the next request restarts from ADDR.
- WR_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never asserts bvalid → after 8 RESP cycles the master gets bvalid=1, bresp=2'b10; bready returns the FSM to IDLE.

Source files
------------

// File: rtl/write_channel_controller.sv
// -----------------------------------------------------------------------------
// write_channel_controller
//
// Write-path sequencer for the 2-master / 1-slave AXI interconnect. It sits
// right after the write arbiter. It accepts the arbiter's Channel_Request and
// Selected_Slave and returns Channel_Granted. For exactly one burst it routes
// the selected master's AW, W and B channels to the single slave port M00. The
// channel stays owned until the write response completes, and then
// arbitration reopens.
//
// Handshake rule for every channel: a transfer happens on the rising ACLK edge
// where VALID and READY are both high. VALID and READY are passed through
// combinationally, so the controller adds no latency inside a burst.
//
// Optional feature macro: WR_TIMEOUT_EN
//   When defined, a response watchdog is included. If the slave withholds
//   bvalid for TIMEOUT_CYCLES cycles in RESP, the FSM moves to ERR. ERR answers
//   the master with SLVERR and ignores any late slave response.
//   When undefined, RESP waits for the slave indefinitely.
//
// Ports
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   Channel_Request        arbiter: a master wants the free channel
//   Selected_Slave         arbiter: granted master index (0 = S00, 1 = S01)
//   Channel_Granted        to arbiter: high only while IDLE
//   S00_AXI_* / S01_AXI_*  master-side AW, W and B channels (wlast is ignored)
//   M00_AXI_*              slave-side AW, W and B channels
//   o_state_dbg            current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module write_channel_controller #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                Channel_Request,
  input  logic                Selected_Slave,
  output logic                Channel_Granted,
  // master 0
  input  logic [ADDR_W-1:0]   S00_AXI_awaddr,
  input  logic [7:0]          S00_AXI_awlen,
  input  logic [2:0]          S00_AXI_awsize,
  input  logic [1:0]          S00_AXI_awburst,
  input  logic                S00_AXI_awvalid,
  output logic                S00_AXI_awready,
  input  logic [DATA_W-1:0]   S00_AXI_wdata,
  input  logic [DATA_W/8-1:0] S00_AXI_wstrb,
  input  logic                S00_AXI_wlast,
  input  logic                S00_AXI_wvalid,
  output logic                S00_AXI_wready,
  output logic [1:0]          S00_AXI_bresp,
  output logic                S00_AXI_bvalid,
  input  logic                S00_AXI_bready,
  // master 1
  input  logic [ADDR_W-1:0]   S01_AXI_awaddr,
  input  logic [7:0]          S01_AXI_awlen,
  input  logic [2:0]          S01_AXI_awsize,
  input  logic [1:0]          S01_AXI_awburst,
  input  logic                S01_AXI_awvalid,
  output logic                S01_AXI_awready,
  input  logic [DATA_W-1:0]   S01_AXI_wdata,
  input  logic [DATA_W/8-1:0] S01_AXI_wstrb,
  input  logic                S01_AXI_wlast,
  input  logic                S01_AXI_wvalid,
  output logic                S01_AXI_wready,
  output logic [1:0]          S01_AXI_bresp,
  output logic                S01_AXI_bvalid,
  input  logic                S01_AXI_bready,
  // slave port
  output logic [ADDR_W-1:0]   M00_AXI_awaddr,
  output logic [7:0]          M00_AXI_awlen,
  output logic [2:0]          M00_AXI_awsize,
  output logic [1:0]          M00_AXI_awburst,
  output logic                M00_AXI_awvalid,
  input  logic                M00_AXI_awready,
  output logic [DATA_W-1:0]   M00_AXI_wdata,
  output logic [DATA_W/8-1:0] M00_AXI_wstrb,
  output logic                M00_AXI_wlast,
  output logic                M00_AXI_wvalid,
  input  logic                M00_AXI_wready,
  input  logic [1:0]          M00_AXI_bresp,
  input  logic                M00_AXI_bvalid,
  output logic                M00_AXI_bready,
  // debug
  output logic [2:0]          o_state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_RESP = 3'd3
`ifdef WR_TIMEOUT_EN
    , S_ERR = 3'd4
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_len_q;
  logic [7:0]  r_beat_cnt;

  // Selected master's request-side signals. Selected_Slave is frozen by the
  // arbiter whenever Channel_Granted is low, so a plain mux is safe.
  logic [ADDR_W-1:0]   w_awaddr;
  logic [7:0]          w_awlen;
  logic [2:0]          w_awsize;
  logic [1:0]          w_awburst;
  logic                w_awvalid;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W/8-1:0] w_wstrb;
  logic                w_wvalid;
  logic                w_bready;

  assign w_awaddr  = Selected_Slave ? S01_AXI_awaddr  : S00_AXI_awaddr;
  assign w_awlen   = Selected_Slave ? S01_AXI_awlen   : S00_AXI_awlen;
  assign w_awsize  = Selected_Slave ? S01_AXI_awsize  : S00_AXI_awsize;
  assign w_awburst = Selected_Slave ? S01_AXI_awburst : S00_AXI_awburst;
  assign w_awvalid = Selected_Slave ? S01_AXI_awvalid : S00_AXI_awvalid;
  assign w_wdata   = Selected_Slave ? S01_AXI_wdata   : S00_AXI_wdata;
  assign w_wstrb   = Selected_Slave ? S01_AXI_wstrb   : S00_AXI_wstrb;
  assign w_wvalid  = Selected_Slave ? S01_AXI_wvalid  : S00_AXI_wvalid;
  assign w_bready  = Selected_Slave ? S01_AXI_bready  : S00_AXI_bready;

  // The master's wlast is ignored. The last beat is derived from the latched
  // awlen, so a misbehaving master cannot end a burst early or late.
  logic w_unused_wlast;
  assign w_unused_wlast = S00_AXI_wlast ^ S01_AXI_wlast;

  logic w_wlast;
  logic w_aw_hs;
  logic w_w_hs;
  assign w_wlast = (r_beat_cnt == r_len_q);
  assign w_aw_hs = (r_state == S_ADDR) && w_awvalid && M00_AXI_awready;
  assign w_w_hs  = (r_state == S_DATA) && w_wvalid && M00_AXI_wready;

`ifdef WR_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        w_to_hit;
  assign w_to_hit = (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));

  // The counter counts RESP cycles without slave bvalid. It is held at zero
  // outside RESP, so every response window starts from zero.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                r_to_cnt <= 16'd0;
    else if (r_state != S_RESP)  r_to_cnt <= 16'd0;
    else if (!M00_AXI_bvalid)    r_to_cnt <= r_to_cnt + 16'd1;
  end
`else
  logic [15:0] w_unused_timeout;
  assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

  // Response-side signals for the selected master, demuxed below.
  logic       w_awready;
  logic       w_wready;
  logic       w_bvalid;
  logic [1:0] w_bresp;

  always_comb begin
    w_next          = r_state;
    Channel_Granted = 1'b0;
    w_awready       = 1'b0;
    w_wready        = 1'b0;
    w_bvalid        = 1'b0;
    w_bresp         = 2'b00;
    M00_AXI_awaddr  = '0;
    M00_AXI_awlen   = 8'd0;
    M00_AXI_awsize  = 3'd0;
    M00_AXI_awburst = 2'd0;
    M00_AXI_awvalid = 1'b0;
    M00_AXI_wdata   = '0;
    M00_AXI_wstrb   = '0;
    M00_AXI_wlast   = 1'b0;
    M00_AXI_wvalid  = 1'b0;
    M00_AXI_bready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        Channel_Granted = 1'b1;
        if (Channel_Request) w_next = S_ADDR;
      end
      S_ADDR: begin
        M00_AXI_awaddr  = w_awaddr;
        M00_AXI_awlen   = w_awlen;
        M00_AXI_awsize  = w_awsize;
        M00_AXI_awburst = w_awburst;
        M00_AXI_awvalid = w_awvalid;
        w_awready       = M00_AXI_awready;
        if (w_aw_hs) w_next = S_DATA;
      end
      S_DATA: begin
        M00_AXI_wdata  = w_wdata;
        M00_AXI_wstrb  = w_wstrb;
        M00_AXI_wvalid = w_wvalid;
        M00_AXI_wlast  = w_wlast;
        w_wready       = M00_AXI_wready;
        if (w_w_hs && w_wlast) w_next = S_RESP;
      end
      S_RESP: begin
        w_bvalid       = M00_AXI_bvalid;
        w_bresp        = M00_AXI_bresp;
        M00_AXI_bready = w_bready;
        if (M00_AXI_bvalid && w_bready) w_next = S_IDLE;
`ifdef WR_TIMEOUT_EN
        else if (!M00_AXI_bvalid && w_to_hit) w_next = S_ERR;
`endif
      end
`ifdef WR_TIMEOUT_EN
      S_ERR: begin
        // Local SLVERR. The slave's B channel stays disconnected, so a late
        // response can never reach the master.
        w_bvalid = 1'b1;
        w_bresp  = 2'b10;
        if (w_bready) w_next = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  assign S00_AXI_awready = !Selected_Slave && w_awready;
  assign S01_AXI_awready =  Selected_Slave && w_awready;
  assign S00_AXI_wready  = !Selected_Slave && w_wready;
  assign S01_AXI_wready  =  Selected_Slave && w_wready;
  assign S00_AXI_bvalid  = !Selected_Slave && w_bvalid;
  assign S01_AXI_bvalid  =  Selected_Slave && w_bvalid;
  assign S00_AXI_bresp   = Selected_Slave ? 2'b00 : w_bresp;
  assign S01_AXI_bresp   = Selected_Slave ? w_bresp : 2'b00;

  assign o_state_dbg = r_state;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // The beat counter holds on the final beat, so awlen=255 ends at 255 and
  // does not wrap back to 0.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_len_q    <= 8'd0;
      r_beat_cnt <= 8'd0;
    end else if (w_aw_hs) begin
      r_len_q    <= w_awlen;
      r_beat_cnt <= 8'd0;
    end else if (w_w_hs && !w_wlast) begin
      r_beat_cnt <= r_beat_cnt + 8'd1;
    end
  end

endmodule
